relm_uart: RTL and testbench
============================

RELM_UART -- requirements
Module: relm_uart

Interface
REQ-001 SHALL have parameter WD, default 32, which is the push/pop word width excluding the valid bit.
REQ-002 SHALL have parameter CLKDIV, default 434, which is clk cycles per bit (115200 baud at 50 MHz); legal range 4..65535.
REQ-003 SHALL have parameter PARITY, default 0, selecting 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter WAD_RX, default 4, which is log2 of the RX FIFO depth.
REQ-005 SHALL have parameter WAD_TX, default 4, which is log2 of the TX FIFO depth.
REQ-006 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n_in  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port uart_in  input  1  serial RX line, asynchronous to clk.
REQ-009 SHALL have port uart_out  output  1  serial TX line; idle high.
REQ-010 SHALL have port push_d  input  WD+1  push word: [WD] is push strobe, [7:0] is TX byte.
REQ-011 SHALL have port push_retry  output  1  high = TX FIFO full, push not accepted.
REQ-012 SHALL have port pop_d  input  WD+1  pop command: [WD] pops RX head, [WD-1] clears sticky errors.
REQ-013 SHALL have port pop_q  output  WD+1  status word: [WD] RX empty, [WD-1] TX FIFO full, [WD-2] overrun, [WD-3] framing error, [WD-4] parity error, [7:0] RX head byte, other bits 0.

Function
REQ-014 SHALL pass uart_in through a 2-flop synchronizer reset to 1; all RX decisions use the synchronized value.
REQ-015 SHALL frame as 1 start bit (0), 8 data bits LSB first, an optional parity bit, and 1 stop bit (1).
REQ-016 SHALL run the RX FSM through IDLE, START, DATA, PAR, STOP, WAIT_HIGH, with PAR skipped when PARITY=0.
REQ-017 SHALL enter START from IDLE on a synchronized 1-to-0 transition, and after CLKDIV/2 cycles go to DATA if the line is still 0, else return to IDLE (glitch reject).
REQ-018 SHALL sample each DATA, PAR and STOP bit exactly CLKDIV cycles after the previous sample point, using a 16-bit down-counter.
REQ-019 SHALL, at STOP with the line at 1 and parity OK, write the byte to the RX FIFO if it is not full, else drop the byte and set overrun; then go to IDLE.
REQ-020 SHALL, at STOP with the line at 0, drop the byte, set the framing sticky, and enter WAIT_HIGH, which exits to IDLE on the first synchronized 1.
REQ-021 SHALL, on parity mismatch, drop the byte and set the parity sticky; the stop bit is still checked.
REQ-022 SHALL hold the sticky error bits until a cycle with pop_d[WD-1]=1; if a new error occurs in the same cycle as a clear, the new error wins.
REQ-023 SHALL, on pop_d[WD]=1 with the RX FIFO non-empty, advance the head so the new head appears on pop_q the next cycle; a pop when empty is ignored.
REQ-024 SHALL drive pop_q registered, with pop_q[WD]=1 whenever the RX FIFO is empty and [7:0] then holding 0.
REQ-025 SHALL accept a push when push_d[WD]=1 and push_retry=0; a push with push_retry=1 is discarded with no state change.
REQ-026 SHALL derive push_retry from the registered TX count only, so a same-cycle TX FSM dequeue does not unblock a push while full.
REQ-027 SHALL run the TX FSM through IDLE, START, DATA, PAR, STOP, holding each bit for CLKDIV cycles.
REQ-028 SHALL, in IDLE with the TX FIFO non-empty, dequeue and drive uart_out=0 within 2 cycles of the push being accepted.
REQ-029 SHALL, at the end of STOP with the TX FIFO non-empty, go directly to START with no idle gap (back-to-back frames).
REQ-030 SHALL compute odd parity as the inverse of the XOR of the 8 bits, and even parity as the XOR.
REQ-031 SHALL use FIFO pointers that are WAD+1 bits wide, wrapping modulo the depth; full and empty are taken from the pointer MSB comparison.
REQ-032 SHALL, on a simultaneous write and read to the RX FIFO, keep the count unchanged; when the FIFO is full, the write is refused before the read is considered.

Reset
REQ-033 SHALL, while rst_n_in=0, asynchronously force uart_out=1, both FSMs to IDLE, both FIFOs empty, sticky bits 0, counters 0, and the synchronizer to 1.
REQ-034 SHALL, when reset asserts mid-frame, release uart_out high immediately, discard any partial RX byte, and not emit that frame after release.
REQ-035 SHALL drive pop_q to {1'b1, 0...} and push_retry to 0 during reset.

Structure
REQ-036 SHALL place the RX/TX state encodings, the PARITY codes (NONE=0, ODD=1, EVEN=2) and the pop_q bit-position constants in package relm_uart_pkg.
REQ-037 SHALL implement both FIFOs as one sub-module, relm_uart_fifo (parameters WAD and WD=8, async reset, registered q), instantiated twice.
REQ-038 SHALL give RX and TX independent counters, with no shared baud tick.

Verification (CLKDIV=8, PARITY=2, WAD_RX=WAD_TX=2)
REQ-039 SHALL test a push of 0x55 when idle -> uart_out falls within 2 cycles, then shows 1,0,1,0,1,0,1,0, parity 0, stop 1, each held 8 cycles.
REQ-040 SHALL test pushing 5 bytes in consecutive cycles -> push_retry=1 on the 5th push and that byte is dropped; the 4 frames go out back-to-back with no gap.
REQ-041 SHALL test RX of 0xA3 with correct parity -> pop_q[WD]=0 and [7:0]=0xA3; after a pop, pop_q[WD]=1 the next cycle.
REQ-042 SHALL test 5 RX frames with no pops -> 4 bytes are stored and the overrun sticky is set; pop_d[WD-1]=1 clears it.
REQ-043 SHALL test an RX frame whose stop bit is 0 -> the framing sticky is set, nothing is stored, and the next frame is received only after the line returns high.
REQ-044 SHALL test a 2-cycle low glitch on uart_in, plus rst_n_in pulsed mid-TX frame -> no byte stored, and uart_out=1 immediately with no resumed frame.

Source files
------------

// File: rtl/relm_uart_pkg.sv
// Shared constants for the relm_uart block: FSM encodings, parity codes,
// status-word bit offsets and the parity helper.
package relm_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_PAR       = 3'd3;
    localparam logic [2:0] RX_STOP      = 3'd4;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_START = 3'd1;
    localparam logic [2:0] TX_DATA  = 3'd2;
    localparam logic [2:0] TX_PAR   = 3'd3;
    localparam logic [2:0] TX_STOP  = 3'd4;

    // pop_q status bits sit at WD minus these offsets
    localparam int POPQ_EMPTY_OFS  = 0;
    localparam int POPQ_TXFULL_OFS = 1;
    localparam int POPQ_OVR_OFS    = 2;
    localparam int POPQ_FRM_OFS    = 3;
    localparam int POPQ_PERR_OFS   = 4;

    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        logic p;
        case (mode)
            PAR_ODD:  p = ~(^d);
            PAR_EVEN: p = ^d;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/relm_uart_fifo.sv
// Synchronous FIFO with registered head, full and empty flags; the head
// register is loaded with the look-ahead value so it is valid the cycle after.
module relm_uart_fifo #(
    parameter int WAD = 4,
    parameter int WD  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [WD-1:0] wd,
    input  logic          rd,
    output logic [WD-1:0] q,
    output logic          full,
    output logic          empty
);
    localparam int           DEPTH   = 1 << WAD;
    localparam logic [WAD:0] PTR_ONE = {{WAD{1'b0}}, 1'b1};

    logic [WD-1:0] r_mem [DEPTH];
    logic [WAD:0]  r_wp;
    logic [WAD:0]  r_rp;
    logic [WD-1:0] r_q;
    logic          r_full;
    logic          r_empty;
    logic [WAD:0]  w_wp_nxt;
    logic [WAD:0]  w_rp_nxt;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_empty_nxt;
    logic          w_full_nxt;
    logic [WD-1:0] w_q_nxt;

    // a full FIFO refuses the write regardless of a same-cycle read
    assign w_wr_en     = wr & ~r_full;
    assign w_rd_en     = rd & ~r_empty;
    assign w_wp_nxt    = w_wr_en ? (r_wp + PTR_ONE) : r_wp;
    assign w_rp_nxt    = w_rd_en ? (r_rp + PTR_ONE) : r_rp;
    assign w_empty_nxt = (w_wp_nxt == w_rp_nxt);
    assign w_full_nxt  = (w_wp_nxt[WAD] != w_rp_nxt[WAD]) &&
                         (w_wp_nxt[WAD-1:0] == w_rp_nxt[WAD-1:0]);

    // next head: bypass the incoming word when it becomes the only entry
    always_comb begin
        if (w_empty_nxt) begin
            w_q_nxt = '0;
        end else if (w_wr_en && (r_wp[WAD-1:0] == w_rp_nxt[WAD-1:0])) begin
            w_q_nxt = wd;
        end else begin
            w_q_nxt = r_mem[w_rp_nxt[WAD-1:0]];
        end
    end

    // storage array
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wp[WAD-1:0]] <= wd;
        end
    end

    // pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_q     <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wp    <= w_wp_nxt;
            r_rp    <= w_rp_nxt;
            r_q     <= w_q_nxt;
            r_full  <= w_full_nxt;
            r_empty <= w_empty_nxt;
        end
    end

    assign q     = r_q;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: rtl/relm_uart.sv
// UART with independent RX/TX bit timers, an RX and a TX FIFO, and sticky
// overrun / framing / parity status exposed on a registered status word.
module relm_uart
    import relm_uart_pkg::*;
#(
    parameter int WD     = 32,
    parameter int CLKDIV = 434,
    parameter int PARITY = 0,
    parameter int WAD_RX = 4,
    parameter int WAD_TX = 4
) (
    input  logic        clk,
    input  logic        rst_n_in,
    input  logic        uart_in,
    output logic        uart_out,
    input  logic [WD:0] push_d,
    output logic        push_retry,
    input  logic [WD:0] pop_d,
    output logic [WD:0] pop_q
);
    localparam logic [15:0] DIV_M1  = 16'(CLKDIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLKDIV / 2 - 1);

    logic        r_sync1, r_sync2, r_rx_prev;
    logic [2:0]  r_rx_st;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_sh;
    logic        r_rx_perr;
    logic        r_ovr, r_frm, r_perr;
    logic [2:0]  r_tx_st;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_sh;
    logic        r_tx_par;
    logic        r_uart_out;

    logic        w_rx_full, w_rx_empty, w_rx_wr, w_rx_good, w_rx_stop_hit;
    logic        w_set_ovr, w_set_frm, w_set_perr, w_par_bad, w_clr;
    logic [7:0]  w_rx_q;
    logic        w_tx_full, w_tx_empty, w_tx_rd;
    logic [7:0]  w_tx_q;
    logic        w_unused;

    assign w_unused      = ^{push_d[WD-1:8], pop_d[WD-2:0]};
    assign w_clr         = pop_d[WD-1];
    assign w_par_bad     = (r_sync2 != parity_bit(r_rx_sh, PARITY));
    assign w_rx_stop_hit = (r_rx_st == RX_STOP) && (r_rx_cnt == 16'd0);
    assign w_rx_good     = w_rx_stop_hit & r_sync2 & ~r_rx_perr;
    assign w_rx_wr       = w_rx_good & ~w_rx_full;
    assign w_set_ovr     = w_rx_good & w_rx_full;
    assign w_set_frm     = w_rx_stop_hit & ~r_sync2;
    assign w_set_perr    = (r_rx_st == RX_PAR) && (r_rx_cnt == 16'd0) && w_par_bad;

    // input synchronizer and RX frame FSM
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_st   <= RX_IDLE;
            r_rx_cnt  <= 16'd0;
            r_rx_bit  <= 3'd0;
            r_rx_sh   <= 8'd0;
            r_rx_perr <= 1'b0;
        end else begin
            r_sync1   <= uart_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            case (r_rx_st)
                RX_IDLE: begin
                    if (r_rx_prev && !r_sync2) begin
                        r_rx_st   <= RX_START;
                        r_rx_cnt  <= HALF_M1;
                        r_rx_perr <= 1'b0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt != 16'd0) begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end else if (!r_sync2) begin
                        r_rx_st  <= RX_DATA;
                        r_rx_cnt <= DIV_M1;
                        r_rx_bit <= 3'd0;
                    end else begin
                        r_rx_st <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt != 16'd0) begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end else begin
                        r_rx_sh  <= {r_sync2, r_rx_sh[7:1]};
                        r_rx_cnt <= DIV_M1;
                        r_rx_bit <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_st <= (PARITY == PAR_NONE) ? RX_STOP : RX_PAR;
                        end
                    end
                end
                RX_PAR: begin
                    if (r_rx_cnt != 16'd0) begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end else begin
                        r_rx_perr <= w_par_bad;
                        r_rx_cnt  <= DIV_M1;
                        r_rx_st   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt != 16'd0) begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end else begin
                        r_rx_st <= r_sync2 ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (r_sync2) begin
                        r_rx_st <= RX_IDLE;
                    end
                end
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end

    // sticky errors: a new error in the clear cycle survives the clear
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ovr  <= 1'b0;
            r_frm  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            r_ovr  <= w_set_ovr  | (r_ovr  & ~w_clr);
            r_frm  <= w_set_frm  | (r_frm  & ~w_clr);
            r_perr <= w_set_perr | (r_perr & ~w_clr);
        end
    end

    assign w_tx_rd = ~w_tx_empty &
                     ((r_tx_st == TX_IDLE) || ((r_tx_st == TX_STOP) && (r_tx_cnt == 16'd0)));

    // TX frame FSM; a dequeue from IDLE or end-of-STOP starts the next frame
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tx_st    <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_sh    <= 8'd0;
            r_tx_par   <= 1'b0;
            r_uart_out <= 1'b1;
        end else if (w_tx_rd) begin
            r_tx_st    <= TX_START;
            r_tx_cnt   <= DIV_M1;
            r_tx_sh    <= w_tx_q;
            r_tx_par   <= parity_bit(w_tx_q, PARITY);
            r_uart_out <= 1'b0;
        end else if ((r_tx_st != TX_IDLE) && (r_tx_cnt != 16'd0)) begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
        end else begin
            r_tx_cnt <= DIV_M1;
            case (r_tx_st)
                TX_IDLE: r_uart_out <= 1'b1;
                TX_START: begin
                    r_tx_st    <= TX_DATA;
                    r_tx_bit   <= 3'd0;
                    r_uart_out <= r_tx_sh[0];
                end
                TX_DATA: begin
                    r_tx_bit <= r_tx_bit + 3'd1;
                    r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                    if (r_tx_bit != 3'd7) begin
                        r_uart_out <= r_tx_sh[1];
                    end else if (PARITY == PAR_NONE) begin
                        r_tx_st    <= TX_STOP;
                        r_uart_out <= 1'b1;
                    end else begin
                        r_tx_st    <= TX_PAR;
                        r_uart_out <= r_tx_par;
                    end
                end
                TX_PAR: begin
                    r_tx_st    <= TX_STOP;
                    r_uart_out <= 1'b1;
                end
                TX_STOP: begin
                    r_tx_st    <= TX_IDLE;
                    r_uart_out <= 1'b1;
                end
                default: begin
                    r_tx_st    <= TX_IDLE;
                    r_uart_out <= 1'b1;
                end
            endcase
        end
    end

    relm_uart_fifo #(.WAD(WAD_RX), .WD(8)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n_in),
        .wr    (w_rx_wr),
        .wd    (r_rx_sh),
        .rd    (pop_d[WD]),
        .q     (w_rx_q),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    relm_uart_fifo #(.WAD(WAD_TX), .WD(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n_in),
        .wr    (push_d[WD]),
        .wd    (push_d[7:0]),
        .rd    (w_tx_rd),
        .q     (w_tx_q),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    // status word assembled purely from registers
    always_comb begin
        pop_q                       = '0;
        pop_q[WD - POPQ_EMPTY_OFS]  = w_rx_empty;
        pop_q[WD - POPQ_TXFULL_OFS] = w_tx_full;
        pop_q[WD - POPQ_OVR_OFS]    = r_ovr;
        pop_q[WD - POPQ_FRM_OFS]    = r_frm;
        pop_q[WD - POPQ_PERR_OFS]   = r_perr;
        pop_q[7:0]                  = w_rx_q;
    end

    assign push_retry = w_tx_full;
    assign uart_out   = r_uart_out;

endmodule

// File: tb/tb_relm_uart.sv
// Scoreboard bench for relm_uart: stimulus queues expected TX frames and RX
// bytes; independent monitors decode uart_out and drain pop_q.
module tb_relm_uart;
    localparam int WD     = 32;
    localparam int CLKDIV = 8;
    localparam int FRAME  = 11 * CLKDIV;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       b2b;
    } tx_item_t;

    logic        clk;
    logic        rst_n_in;
    logic        uart_in;
    logic        uart_out;
    logic [WD:0] push_d;
    logic        push_retry;
    logic [WD:0] pop_d;
    logic [WD:0] pop_q;
    logic        tb_pop;
    logic        tb_clr;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        tx_mon_en = 1'b1;
    logic        tx_busy = 1'b0;
    logic        rx_auto = 1'b0;
    logic        rx_chk_empty = 1'b0;
    tx_item_t    tx_exp[$];
    logic [7:0]  rx_exp[$];

    assign pop_d = {tb_pop, tb_clr, {(WD-1){1'b0}}};

    relm_uart #(.WD(WD), .CLKDIV(CLKDIV), .PARITY(2), .WAD_RX(2), .WAD_TX(2)) dut (
        .clk        (clk),
        .rst_n_in   (rst_n_in),
        .uart_in    (uart_in),
        .uart_out   (uart_out),
        .push_d     (push_d),
        .push_retry (push_retry),
        .pop_d      (pop_d),
        .pop_q      (pop_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog cycles %0d limit %0d", cyc, 60000);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [WD:0] got, input logic [WD:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // TX monitor: every cycle of a frame must carry the expected line level
    initial begin
        tx_item_t    it;
        logic [10:0] fr;
        logic [7:0]  got;
        int          bad;
        int          start_c;
        int          prev_start;
        logic        have;
        prev_start = 0;
        forever begin
            @(negedge clk);
            if (tx_mon_en && uart_out === 1'b0) begin
                tx_busy = 1'b1;
                start_c = cyc;
                bad = 0;
                got = 8'h00;
                have = (tx_exp.size() != 0);
                if (have) it = tx_exp.pop_front();
                else it = '{8'h00, 1'b0, 1'b0};
                fr = {1'b1, it.par, it.data, 1'b0};
                for (int i = 0; i < FRAME; i++) begin
                    if (i > 0) @(negedge clk);
                    if (uart_out !== fr[i / CLKDIV]) bad++;
                    if ((i % CLKDIV) == CLKDIV / 2 && (i / CLKDIV) >= 1 && (i / CLKDIV) <= 8)
                        got[i / CLKDIV - 1] = uart_out;
                end
                checks++;
                if (!have || bad != 0) begin
                    errors++;
                    $display("FAIL tx_frame got %02h bad_cycles %0d expected %02h queued %0d",
                             got, bad, it.data, have);
                end
                if (have && it.b2b) begin
                    checks++;
                    if (start_c != prev_start + FRAME) begin
                        errors++;
                        $display("FAIL tx_b2b got start %0d expected %0d", start_c, prev_start + FRAME);
                    end
                end
                prev_start = start_c;
                tx_busy = 1'b0;
            end
        end
    end

    // RX monitor: pop and compare whenever a byte is presented
    initial begin
        logic [7:0] e;
        tb_pop = 1'b0;
        forever begin
            @(negedge clk);
            tb_pop = 1'b0;
            if (rx_chk_empty) begin
                rx_chk_empty = 1'b0;
                check("rx_empty_after_pop", {pop_q[WD], pop_q[7:0]}, {1'b1, 8'h00});
            end else if (rx_auto && pop_q[WD] === 1'b0) begin
                checks++;
                if (rx_exp.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected got %02h expected none", pop_q[7:0]);
                end else begin
                    e = rx_exp.pop_front();
                    if (pop_q[7:0] !== e) begin
                        errors++;
                        $display("FAIL rx_byte got %02h expected %02h", pop_q[7:0], e);
                    end
                end
                tb_pop = 1'b1;
                if (rx_exp.size() == 0) rx_chk_empty = 1'b1;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input logic par, input logic exp_retry,
                             input logic b2b, input logic track);
        @(negedge clk);
        push_d = {1'b1, {(WD-8){1'b0}}, b};
        check("push_retry", {{WD{1'b0}}, push_retry}, {{WD{1'b0}}, exp_retry});
        if (!exp_retry && track) tx_exp.push_back('{b, par, b2b});
    endtask

    task automatic rx_send(input logic [7:0] b, input logic par, input logic stop);
        logic [10:0] fr;
        fr = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            uart_in = fr[i];
            repeat (CLKDIV) @(negedge clk);
        end
    endtask

    task automatic rx_idle(input int n);
        uart_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx_done();
        int n;
        n = 0;
        while ((tx_exp.size() != 0 || tx_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("tx_drain_timeout", {{WD{1'b0}}, (n >= 2000)}, '0);
    endtask

    task automatic wait_rx_done();
        int n;
        n = 0;
        while (rx_exp.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("rx_drain_timeout", {{WD{1'b0}}, (n >= 400)}, '0);
    endtask

    task automatic clear_sticky();
        @(negedge clk);
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
        check("sticky_cleared", {{(WD-2){1'b0}}, pop_q[WD-2:WD-4]}, '0);
    endtask

    initial begin
        int k;
        int lows;
        rst_n_in = 1'b0;
        uart_in  = 1'b1;
        push_d   = '0;
        tb_clr   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pop_q", pop_q, {1'b1, {WD{1'b0}}});
        check("rst_push_retry", {{WD{1'b0}}, push_retry}, '0);
        check("rst_uart_out", {{WD{1'b0}}, uart_out}, {{WD{1'b0}}, 1'b1});
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk);

        // single byte 0x55, even parity 0
        push_byte(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        k = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) push_d = '0;
            if (uart_out === 1'b0 && k == 0) k = i;
        end
        checks++;
        if (k < 1 || k > 3) begin
            errors++;
            $display("FAIL tx_start_latency got %0d expected 1..3", k);
        end
        wait_tx_done();

        // lead frame keeps TX busy, then 5 pushes in a row: 5th refused
        push_byte(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        push_d = '0;
        @(negedge clk);
        push_byte(8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
        push_byte(8'h02, 1'b1, 1'b0, 1'b1, 1'b1);
        push_byte(8'h03, 1'b0, 1'b0, 1'b1, 1'b1);
        push_byte(8'h04, 1'b1, 1'b0, 1'b1, 1'b1);
        push_byte(8'h05, 1'b0, 1'b1, 1'b1, 1'b1);
        check("tx_full_status", {{WD{1'b0}}, pop_q[WD-1]}, {{WD{1'b0}}, 1'b1});
        @(negedge clk);
        push_d = '0;
        wait_tx_done();

        // RX 0xA3, even parity 0
        rx_auto = 1'b1;
        rx_exp.push_back(8'hA3);
        rx_send(8'hA3, 1'b0, 1'b1);
        rx_idle(6);
        wait_rx_done();

        // five frames without popping: four stored, overrun on the fifth
        rx_auto = 1'b0;
        rx_send(8'h01, 1'b1, 1'b1); rx_idle(6);
        rx_send(8'h22, 1'b0, 1'b1); rx_idle(6);
        rx_send(8'h37, 1'b1, 1'b1); rx_idle(6);
        rx_send(8'h44, 1'b0, 1'b1); rx_idle(6);
        rx_send(8'h80, 1'b1, 1'b1); rx_idle(6);
        check("overrun_set", {{(WD-2){1'b0}}, pop_q[WD], pop_q[WD-2:WD-4]}, {{(WD-2){1'b0}}, 4'b0100});
        rx_exp.push_back(8'h01);
        rx_exp.push_back(8'h22);
        rx_exp.push_back(8'h37);
        rx_exp.push_back(8'h44);
        rx_auto = 1'b1;
        wait_rx_done();
        clear_sticky();

        // stop bit 0, line held low, then a good frame after release
        rx_send(8'h5A, 1'b0, 1'b0);
        repeat (24) @(negedge clk);
        check("framing_set", {{(WD-2){1'b0}}, pop_q[WD], pop_q[WD-2:WD-4]}, {{(WD-2){1'b0}}, 4'b1010});
        rx_idle(6);
        rx_exp.push_back(8'hC6);
        rx_send(8'hC6, 1'b0, 1'b1);
        rx_idle(6);
        wait_rx_done();
        clear_sticky();

        // wrong parity bit: byte dropped, parity sticky set
        rx_send(8'h5A, 1'b1, 1'b1);
        rx_idle(6);
        check("parity_set", {{(WD-2){1'b0}}, pop_q[WD], pop_q[WD-2:WD-4]}, {{(WD-2){1'b0}}, 4'b1001});
        clear_sticky();

        // two-cycle low glitch must be rejected
        uart_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_idle(30);
        check("glitch_reject", {{(WD-2){1'b0}}, pop_q[WD], pop_q[WD-2:WD-4]}, {{(WD-2){1'b0}}, 4'b1000});

        // reset mid TX frame: line high at once, frame not resumed
        tx_mon_en = 1'b0;
        push_byte(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        push_d = '0;
        repeat (30) @(negedge clk);
        rst_n_in = 1'b0;
        #1;
        check("rst_mid_uart_out", {{WD{1'b0}}, uart_out}, {{WD{1'b0}}, 1'b1});
        check("rst_mid_pop_q", pop_q, {1'b1, {WD{1'b0}}});
        check("rst_mid_push_retry", {{WD{1'b0}}, push_retry}, '0);
        repeat (3) @(negedge clk);
        rst_n_in = 1'b1;
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (uart_out !== 1'b1) lows++;
        end
        check("no_resumed_frame", lows, '0);
        tx_mon_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
